// File: rtl/gutteroil_pkg.sv
// Shared types and sizing helpers for the nearest-neighbour distance stage.
// Pure declarations: no latency, no flow control.
// Consumers size their ports from the functions below.
package gutteroil_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CMP   = 2'd2,
        FIN   = 2'd3
    } knn_state_t;

    localparam int DS_W = 16;

    function automatic int default_acc_w(input int num_feat);
        return DS_W + $clog2(num_feat);
    endfunction

    function automatic int idx_width(input int num_samples);
        return (num_samples > 1) ? $clog2(num_samples) : 1;
    endfunction

endpackage

// File: rtl/knn_min_dist_dist_acc.sv
// Distance accumulator: sums zero-extended squared-difference terms, clear has priority.
// Latency 1 cycle (sum visible the cycle after the add); no backpressure, caller gates i_add.
// KNN_MIN_DIST_SAT_EN selects saturation at all-ones instead of modulo wrap.
module dist_acc
    import gutteroil_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [DS_W-1:0]  i_term,
    output logic [ACC_W-1:0] o_acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_next;

`ifdef KNN_MIN_DIST_SAT_EN
    logic [ACC_W:0] w_sum;
    assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(i_term);
    // A saturated sum stays in the running so an overflowing sample never wins by wrapping.
    assign w_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_next = r_acc + ACC_W'(i_term);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/knn_min_dist.sv
// Nearest-neighbour search: per-sample squared distance, running minimum with index and label.
// Latency: last term of last sample to done = 2 cycles; min_* stable in the done cycle.
// Backpressure: ds_ready only in ACCUM; terms offered otherwise are dropped. KNN_MIN_DIST_SAT_EN in dist_acc.
module knn_min_dist
    import gutteroil_pkg::*;
#(
    parameter  int NUM_FEAT    = 8,
    parameter  int NUM_SAMPLES = 16,
    parameter  int ACC_W       = 20,
    parameter  int LABEL_W     = 2,
    localparam int IDX_W       = idx_width(NUM_SAMPLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ds_valid,
    input  logic [DS_W-1:0]    ds_result,
    input  logic [LABEL_W-1:0] ds_label,
    output logic               ds_ready,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   min_dist,
    output logic [IDX_W-1:0]   min_idx,
    output logic [LABEL_W-1:0] min_label
);

    localparam int FEAT_W = $clog2(NUM_FEAT);

    knn_state_t         r_state;
    logic [FEAT_W-1:0]  r_feat_cnt;
    logic [IDX_W-1:0]   r_sample_cnt;
    logic               r_have_min;
    logic [LABEL_W-1:0] r_label;
    logic               r_ds_ready;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_min_dist;
    logic [IDX_W-1:0]   r_min_idx;
    logic [LABEL_W-1:0] r_min_label;

    logic               w_acc_clr;
    logic               w_acc_add;
    logic [ACC_W-1:0]   w_acc;

    assign w_acc_clr = ((r_state == IDLE) && start) || (r_state == CMP);
    assign w_acc_add = (r_state == ACCUM) && ds_valid;

    dist_acc #(
        .ACC_W (ACC_W)
    ) u_dist_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_acc_clr),
        .i_add  (w_acc_add),
        .i_term (ds_result),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_feat_cnt   <= '0;
            r_sample_cnt <= '0;
            r_have_min   <= 1'b0;
            r_label      <= '0;
            r_ds_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_min_dist   <= '0;
            r_min_idx    <= '0;
            r_min_label  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_feat_cnt   <= '0;
                        r_sample_cnt <= '0;
                        r_have_min   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_ds_ready   <= 1'b1;
                        r_state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (ds_valid) begin
                        if (r_feat_cnt == '0) begin
                            r_label <= ds_label;
                        end
                        if (r_feat_cnt == FEAT_W'(NUM_FEAT - 1)) begin
                            r_feat_cnt <= '0;
                            r_ds_ready <= 1'b0;
                            r_state    <= CMP;
                        end else begin
                            r_feat_cnt <= r_feat_cnt + FEAT_W'(1);
                        end
                    end
                end
                CMP: begin
                    // Strict less-than: on a tie the earlier sample keeps the slot.
                    if (!r_have_min || (w_acc < r_min_dist)) begin
                        r_min_dist  <= w_acc;
                        r_min_idx   <= r_sample_cnt;
                        r_min_label <= r_label;
                    end
                    r_have_min <= 1'b1;
                    r_feat_cnt <= '0;
                    if (r_sample_cnt == IDX_W'(NUM_SAMPLES - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + IDX_W'(1);
                        r_ds_ready   <= 1'b1;
                        r_state      <= ACCUM;
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ds_ready  = r_ds_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign min_dist  = r_min_dist;
    assign min_idx   = r_min_idx;
    assign min_label = r_min_label;

endmodule

// File: tb/tb_knn_min_dist.sv
// Directed bench for knn_min_dist (NUM_FEAT=4, NUM_SAMPLES=3, ACC_W=16) with a result scoreboard.
module tb_knn_min_dist;

    localparam int NF = 4;
    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ds_valid = 1'b0;
    logic [15:0] ds_result = '0;
    logic [1:0]  ds_label = '0;
    logic        ds_ready;
    logic        busy;
    logic        done;
    logic [15:0] min_dist;
    logic [1:0]  min_idx;
    logic [1:0]  min_label;

    knn_min_dist #(
        .NUM_FEAT    (NF),
        .NUM_SAMPLES (NS),
        .ACC_W       (16),
        .LABEL_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ds_valid  (ds_valid),
        .ds_result (ds_result),
        .ds_label  (ds_label),
        .ds_ready  (ds_ready),
        .busy      (busy),
        .done      (done),
        .min_dist  (min_dist),
        .min_idx   (min_idx),
        .min_label (min_label)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  i;
        logic [1:0]  l;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] tv[NS][NF];
    logic [1:0]  lv[NS];
    logic [15:0] last_dist = '0;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] acc_add(input logic [15:0] a, input logic [15:0] t);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, t};
`ifdef KNN_MIN_DIST_SAT_EN
        return s[16] ? 16'hFFFF : s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the term was accepted.
    task automatic push_term(input logic [15:0] t, input logic [1:0] l, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        while (!ds_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(ds_ready), 32'd1);
        ds_valid  = 1'b1;
        ds_result = t;
        ds_label  = l;
        @(negedge clk);
        ds_valid  = 1'b0;
    endtask

    task automatic run(input string tag, input bit gaps, input bit inject, input bit restart);
        exp_t        e;
        logic [15:0] s;
        bit          first = 1'b1;
        int          n;
        int          dones = 0;
        e = '0;
        for (int k = 0; k < NS; k++) begin
            s = '0;
            for (int f = 0; f < NF; f++) s = acc_add(s, tv[k][f]);
            if (first || s < e.d) begin
                e.d = s;
                e.i = 2'(k);
                e.l = lv[k];
            end
            first = 1'b0;
        end
        sb.push_back(e);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_min_held"}, 32'(min_dist), 32'(last_dist));

        for (int k = 0; k < NS; k++) begin
            for (int f = 0; f < NF; f++) begin
                push_term(tv[k][f], lv[k], gaps && !(k == NS-1 && f == NF-1));
                if (restart && k == 0 && f == 0) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                if (inject && f == NF-1 && k < NS-1) begin
                    chk({tag, "_ready_cmp"}, 32'(ds_ready), 32'd0);
                    ds_valid  = 1'b1;
                    ds_result = 16'd777;
                    @(negedge clk);
                    ds_valid  = 1'b0;
                end
            end
        end

        n = 1;
        chk({tag, "_no_early_done"}, 32'(done), 32'd0);
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        e = sb.pop_front();
        chk({tag, "_dist"}, 32'(min_dist), 32'(e.d));
        chk({tag, "_idx"}, 32'(min_idx), 32'(e.i));
        chk({tag, "_label"}, 32'(min_label), 32'(e.l));
        last_dist = e.d;
        @(negedge clk);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            dones += int'(done);
            @(negedge clk);
        end
        chk({tag, "_extra_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(ds_ready), 32'd0);
        chk("rst_min", {12'(min_dist), 2'(min_idx), 2'(min_label)}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        tv = '{'{16'd1, 16'd4, 16'd9, 16'd16}, '{16'd4, 16'd4, 16'd4, 16'd4},
               '{16'd100, 16'd50, 16'd25, 16'd25}};
        lv = '{2'd1, 2'd2, 2'd3};
        run("basic", 1'b0, 1'b0, 1'b0);

        tv = '{'{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd4, 16'd3, 16'd2, 16'd1},
               '{16'd10, 16'd10, 16'd5, 16'd5}};
        lv = '{2'd3, 2'd1, 2'd2};
        run("tie", 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < NS; k++) begin
            lv[k] = 2'($urandom_range(0, 3));
            for (int f = 0; f < NF; f++) tv[k][f] = 16'($urandom_range(0, 300));
        end
        run("gaps", 1'b1, 1'b1, 1'b1);

        tv = '{'{16'd65535, 16'd1, 16'd0, 16'd0}, '{16'd5, 16'd5, 16'd5, 16'd5},
               '{16'd100, 16'd100, 16'd100, 16'd100}};
        lv = '{2'd2, 2'd3, 2'd1};
        run("sat", 1'b0, 1'b0, 1'b0);

        // Abort mid-run: sample 0 complete, sample 1 partly fed.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int f = 0; f < NF; f++) push_term(16'd3, 2'd1, 1'b0);
        push_term(16'd3, 2'd2, 1'b0);
        push_term(16'd3, 2'd2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ds_ready), 32'd0);
        chk("abort_min", {12'(min_dist), 2'(min_idx), 2'(min_label)}, 32'd0);
        begin
            int dones = 0;
            for (int c = 0; c < 4; c++) begin
                dones += int'(done);
                @(negedge clk);
            end
            chk("abort_no_done", 32'(dones), 32'd0);
        end
        rst_n = 1'b1;
        last_dist = '0;
        @(negedge clk);

        tv = '{'{16'd7, 16'd7, 16'd7, 16'd7}, '{16'd3, 16'd0, 16'd0, 16'd0},
               '{16'd9, 16'd9, 16'd9, 16'd9}};
        lv = '{2'd0, 2'd3, 2'd2};
        run("recover", 1'b0, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
